// File: rtl/slow_clock_monitor_if.sv
// ---------------------------------------------------------------------------
// slow_clock_monitor_if
// Bundles the control input, the slow clock input and the measurement
// results of slow_clock_monitor.
//   enable       : monitor enable (low forces the monitor idle)
//   slow_in      : slow clock, asynchronous to the monitor clock
//   tick         : one-cycle pulse per accepted rising edge of slow_in
//   period       : last valid measured period in clk cycles
//   period_valid : period holds a valid measurement
//   locked       : measured period is stable
//   lost         : no accepted edge within the timeout window
//   edge_count   : accepted rising edges, wraps 255 -> 0
// master = stimulus/consumer side, slave = monitor side.
// ---------------------------------------------------------------------------
interface slow_clock_monitor_if #(
  parameter int CNT_W = 26
);
  logic             enable;
  logic             slow_in;
  logic             tick;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             locked;
  logic             lost;
  logic [7:0]       edge_count;

  modport master (
    output enable, slow_in,
    input  tick, period, period_valid, locked, lost, edge_count
  );

  modport slave (
    input  enable, slow_in,
    output tick, period, period_valid, locked, lost, edge_count
  );
endinterface

// File: rtl/slow_clock_monitor.sv
// ---------------------------------------------------------------------------
// slow_clock_monitor
// Brings a slow divided clock into the clk domain, emits a one-cycle tick per
// rising edge (used downstream as a clock enable), measures the slow period in
// clk cycles, reports lock once consecutive periods agree within TOL and
// flags loss when no edge arrives within TIMEOUT cycles.
// Ports:
//   clk   : fast system clock
//   reset : asynchronous, active-high reset
//   bus   : slow_clock_monitor_if.slave (enable, slow_in in; tick, period,
//           period_valid, locked, lost, edge_count out, all registered)
// ---------------------------------------------------------------------------
module slow_clock_monitor #(
  parameter int               SYNC_STAGES = 2,
  parameter int               CNT_W       = 26,
  parameter logic [CNT_W-1:0] TIMEOUT     = 26'd3000000,
  parameter logic [CNT_W-1:0] TOL         = 26'd4,
  parameter int               LOCK_COUNT  = 3
) (
  input logic                 clk,
  input logic                 reset,
  slow_clock_monitor_if.slave bus
);

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_WAIT_FIRST = 2'd1;
  localparam logic [1:0] ST_MEASURE    = 2'd2;
  localparam logic [1:0] ST_LOST       = 2'd3;

  localparam logic [3:0]       LOCK_MAX = 4'(LOCK_COUNT);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [1:0]             r_state;
  logic [CNT_W-1:0]       r_gap;
  logic [3:0]             r_stable;
  logic                   r_tick;
  logic [CNT_W-1:0]       r_period;
  logic                   r_period_valid;
  logic                   r_locked;
  logic                   r_lost;
  logic [7:0]             r_edge_count;

  logic                   w_edge;
  logic [CNT_W-1:0]       w_gap_inc;
  logic [CNT_W-1:0]       w_per_new;
  logic [CNT_W-1:0]       w_diff;
  logic                   w_timeout;
  logic                   w_per_stable;
  logic [3:0]             w_stable_inc;

  // Rising edge as seen after synchronisation; prev tracks the last stage.
  assign w_edge = r_sync[SYNC_STAGES-1] & ~r_prev;

  // Gap counter saturates instead of wrapping, so a long silence can never
  // masquerade as a short period.
  assign w_gap_inc = (r_gap == {CNT_W{1'b1}}) ? r_gap : (r_gap + CNT_ONE);

  // The gap is cleared on the edge cycle, so gap+1 is the edge-to-edge period.
  assign w_per_new = r_gap + CNT_ONE;
  assign w_diff    = (w_per_new >= r_period) ? (w_per_new - r_period)
                                             : (r_period - w_per_new);
  assign w_per_stable = r_period_valid & (w_diff <= TOL);
  assign w_stable_inc = (r_stable >= LOCK_MAX) ? LOCK_MAX : (r_stable + 4'd1);

  // Timeout fires on the cycle the gap counter would reach TIMEOUT.
  assign w_timeout = (w_gap_inc >= TIMEOUT);

  // Synchroniser chain and edge-detect history; runs independent of enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.slow_in};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  // Monitor state machine, gap counter and registered results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_gap          <= '0;
      r_stable       <= 4'd0;
      r_tick         <= 1'b0;
      r_period       <= '0;
      r_period_valid <= 1'b0;
      r_locked       <= 1'b0;
      r_lost         <= 1'b0;
      r_edge_count   <= 8'd0;
    end else begin
      r_tick <= 1'b0;
      if (!bus.enable) begin
        // Any edge seen while disabled is dropped; results hold.
        r_state <= ST_IDLE;
        r_gap   <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_WAIT_FIRST;
            r_gap   <= '0;
          end
          ST_WAIT_FIRST, ST_MEASURE, ST_LOST: begin
            if (w_edge) begin
              // An edge always beats a simultaneous timeout.
              r_tick       <= 1'b1;
              r_edge_count <= r_edge_count + 8'd1;
              r_gap        <= '0;
              r_lost       <= 1'b0;
              r_state      <= ST_MEASURE;
              // Only a MEASURE-state gap spans two accepted edges.
              if (r_state == ST_MEASURE) begin
                r_period       <= w_per_new;
                r_period_valid <= 1'b1;
                if (w_per_stable) begin
                  r_stable <= w_stable_inc;
                  r_locked <= (w_stable_inc == LOCK_MAX);
                end else begin
                  r_stable <= 4'd0;
                  r_locked <= 1'b0;
                end
              end
            end else begin
              r_gap <= w_gap_inc;
              if ((r_state != ST_LOST) && w_timeout) begin
                r_state  <= ST_LOST;
                r_lost   <= 1'b1;
                r_locked <= 1'b0;
                r_stable <= 4'd0;
              end
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_gap   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.tick         = r_tick;
  assign bus.period       = r_period;
  assign bus.period_valid = r_period_valid;
  assign bus.locked       = r_locked;
  assign bus.lost         = r_lost;
  assign bus.edge_count   = r_edge_count;

endmodule

// File: tb/tb_slow_clock_monitor.sv
// ---------------------------------------------------------------------------
// tb_slow_clock_monitor
// Drives slow_in/enable cycle by cycle (directed scenarios plus $urandom
// sequences) and compares every output after every clock edge against a
// timestamp-based reference model: periods are differences between accepted
// edge times, timeouts are elapsed time since the last accepted edge.
// ---------------------------------------------------------------------------
module tb_slow_clock_monitor;

  localparam int CNT_W   = 26;
  localparam int SS      = 2;
  localparam int TIMEOUT = 100;
  localparam int TOL     = 4;
  localparam int LC      = 3;

  logic clk = 1'b0;
  logic reset;

  slow_clock_monitor_if #(.CNT_W(CNT_W)) bus ();

  slow_clock_monitor #(
    .SYNC_STAGES (SS),
    .CNT_W       (CNT_W),
    .TIMEOUT     (26'd100),
    .TOL         (26'd4),
    .LOCK_COUNT  (LC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state
  int        now;          // index of the current clock edge
  int        last_clear;   // edge index at which the last gap started
  int        m_mode;       // 0 idle, 1 waiting first edge, 2 measuring, 3 lost
  logic [SS:0] hist;       // slow_in samples, [0] = most recent
  int        m_period;
  bit        m_valid, m_locked, m_lost, m_tick;
  int        m_count;
  int        m_stable;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    now = 0; last_clear = 0; m_mode = 0; hist = '0;
    m_period = 0; m_valid = 0; m_locked = 0; m_lost = 0; m_tick = 0;
    m_count = 0; m_stable = 0;
  endtask

  task automatic model_clock(input logic s, input logic en);
    logic ed;
    int   per, d;
    now++;
    ed   = hist[SS-1] & ~hist[SS];
    hist = {hist[SS-1:0], s};
    m_tick = 0;
    if (!en) begin
      m_mode = 0; last_clear = now;
    end else if (m_mode == 0) begin
      m_mode = 1; last_clear = now;
    end else if (ed) begin
      m_tick  = 1;
      m_count = (m_count + 1) % 256;
      if (m_mode == 2) begin
        per = now - last_clear;
        d = per - m_period;
        if (d < 0) d = -d;
        if (m_valid && d <= TOL) m_stable = (m_stable + 1 > LC) ? LC : m_stable + 1;
        else m_stable = 0;
        m_locked = (m_stable == LC);
        m_period = per;
        m_valid  = 1;
      end
      m_lost = 0; m_mode = 2; last_clear = now;
    end else if ((m_mode == 1 || m_mode == 2) && (now - last_clear >= TIMEOUT)) begin
      m_mode = 3; m_lost = 1; m_locked = 0; m_stable = 0;
    end
  endtask

  task automatic check_all();
    check_val("tick",         32'(bus.tick),         32'(m_tick));
    check_val("period",       32'(bus.period),       32'(m_period));
    check_val("period_valid", 32'(bus.period_valid), 32'(m_valid));
    check_val("locked",       32'(bus.locked),       32'(m_locked));
    check_val("lost",         32'(bus.lost),         32'(m_lost));
    check_val("edge_count",   32'(bus.edge_count),   32'(m_count));
  endtask

  // One clock cycle: drive inputs, clock, update model, check.
  task automatic step(input logic s, input logic en);
    bus.slow_in = s;
    bus.enable  = en;
    @(posedge clk);
    if (reset) model_reset();
    else model_clock(s, en);
    #1;
    check_all();
  endtask

  task automatic wave(input int per, input int hi, input int n, input logic en);
    for (int k = 0; k < n; k++)
      for (int i = 0; i < per; i++)
        step(i < hi, en);
  endtask

  // Reset asserted away from any clock edge; outputs must clear at once.
  task automatic async_reset();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_val("async_tick",   32'(bus.tick),         32'd0);
    check_val("async_period", 32'(bus.period),       32'd0);
    check_val("async_valid",  32'(bus.period_valid), 32'd0);
    check_val("async_locked", 32'(bus.locked),       32'd0);
    check_val("async_lost",   32'(bus.lost),         32'd0);
    check_val("async_count",  32'(bus.edge_count),   32'd0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    int r, per;
    reset = 1'b1;
    bus.enable  = 1'b0;
    bus.slow_in = 1'b0;
    model_reset();
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    reset = 1'b0;

    // No slow clock at all: timeout, no tick, no period
    for (int i = 0; i < 110; i++) step(1'b0, 1'b1);
    check_val("silent_lost",  32'(bus.lost),         32'd1);
    check_val("silent_valid", 32'(bus.period_valid), 32'd0);

    // Clean period-40 clock from reset
    async_reset();
    wave(40, 20, 6, 1'b1);
    check_val("sq40_period", 32'(bus.period),     32'd40);
    check_val("sq40_locked", 32'(bus.locked),     32'd1);
    check_val("sq40_count",  32'(bus.edge_count), 32'd6);

    // Alternating 40/50 never locks
    for (int i = 0; i < 4; i++) begin
      wave(40, 20, 1, 1'b1);
      wave(50, 25, 1, 1'b1);
    end
    check_val("alt50_locked", 32'(bus.locked), 32'd0);

    // Alternating 40/43 is within tolerance and locks
    for (int i = 0; i < 4; i++) begin
      wave(40, 20, 1, 1'b1);
      wave(43, 20, 1, 1'b1);
    end
    check_val("alt43_locked", 32'(bus.locked), 32'd1);

    // Stop the slow clock, then resume and relock
    wave(40, 20, 4, 1'b1);
    for (int i = 0; i < 120; i++) step(1'b0, 1'b1);
    check_val("stop_lost",   32'(bus.lost),   32'd1);
    check_val("stop_locked", 32'(bus.locked), 32'd0);
    check_val("stop_period", 32'(bus.period), 32'd40);
    wave(40, 20, 5, 1'b1);
    check_val("resume_lost",   32'(bus.lost),   32'd0);
    check_val("resume_locked", 32'(bus.locked), 32'd1);

    // Enable dropped mid-run, then re-enabled
    wave(40, 20, 3, 1'b1);
    wave(40, 20, 2, 1'b0);
    wave(40, 20, 4, 1'b1);

    // Asynchronous reset in the middle of a high phase
    wave(40, 20, 3, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
    async_reset();

    // 260 edges: edge_count wraps through 0
    wave(8, 4, 260, 1'b1);
    check_val("wrap_count", 32'(bus.edge_count), 32'd4);

    // Randomised mix of jittered clocks, gaps, disables and resets
    for (int it = 0; it < 60; it++) begin
      r = int'($urandom_range(0, 11));
      if (r == 0) begin
        per = int'($urandom_range(5, 30));
        for (int i = 0; i < per; i++) step(1'($urandom_range(0, 1)), 1'b0);
      end else if (r == 1) begin
        per = int'($urandom_range(80, 150));
        for (int i = 0; i < per; i++) step(1'b0, 1'b1);
      end else if (r == 2) begin
        async_reset();
      end else if (r < 9) begin
        per = 30 + int'($urandom_range(0, 6));
        wave(per, int'($urandom_range(1, per - 1)), int'($urandom_range(1, 4)), 1'b1);
      end else begin
        per = int'($urandom_range(4, 60));
        wave(per, int'($urandom_range(1, per - 1)), 1, 1'b1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
